// File: rtl/serpent_xts_hdr_check_pkg.sv
// -----------------------------------------------------------------------------
// serpent_xts_pkg
// Shared constants, state encoding and byte-order helpers for the XTS header
// checker that sits behind the serpent_xts_de decryptor.
// No ports (package).
// -----------------------------------------------------------------------------
package serpent_xts_pkg;

   // Header layout: decrypted area starts at byte offset 64, 16 bytes per block
   localparam logic [31:0] HDR_MAGIC      = 32'h56455241;   // "VERA"
   localparam int          HDR_NUM_BLOCKS = 28;             // offsets 64..511
   localparam int          CRC_FIRST_BLK  = 12;             // offset 256
   localparam int          CRC_LAST_BLK   = 27;             // offset 511

   // CRC-32/IEEE, reflected form
   localparam logic [31:0] CRC32_POLY = 32'hEDB88320;
   localparam logic [31:0] CRC32_INIT = 32'hFFFFFFFF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } hdr_state_e;

   // Byte idx of a block, where byte 0 is the lowest-offset byte in [127:120]
   function automatic logic [7:0] blk_byte(input logic [127:0] blk, input int idx);
      return blk[127-8*idx -: 8];
   endfunction

   // Big-endian 32-bit word idx of a block (word 0 = bytes 0..3)
   function automatic logic [31:0] be_word(input logic [127:0] blk, input int idx);
      return blk[127-32*idx -: 32];
   endfunction

endpackage

// File: rtl/serpent_xts_hdr_check_if.sv
// -----------------------------------------------------------------------------
// serpent_xts_hdr_check_if
// Bundles the beat input and verdict outputs of serpent_xts_hdr_check.
//   i_start       1    new candidate pulse
//   i_data        128  decrypted block, [127:120] = lowest-offset byte
//   i_data_valid  1    i_data carries the next block
//   o_busy        1    candidate in progress
//   o_done        1    verdict pulse
//   o_match       1    verdict (qualified by o_done)
//   o_magic_ok    1    magic result after block 0
//   o_blk_cnt     5    blocks accepted for the current candidate
// master = beat source / verdict consumer, slave = the checker.
// -----------------------------------------------------------------------------
interface serpent_xts_hdr_check_if;

   logic         i_start;
   logic [127:0] i_data;
   logic         i_data_valid;
   logic         o_busy;
   logic         o_done;
   logic         o_match;
   logic         o_magic_ok;
   logic [4:0]   o_blk_cnt;

   modport master (
      output i_start, i_data, i_data_valid,
      input  o_busy, o_done, o_match, o_magic_ok, o_blk_cnt
   );

   modport slave (
      input  i_start, i_data, i_data_valid,
      output o_busy, o_done, o_match, o_magic_ok, o_blk_cnt
   );

endinterface

// File: rtl/serpent_xts_hdr_check_crc32_d128.sv
// -----------------------------------------------------------------------------
// crc32_d128
// Combinational CRC-32/IEEE (reflected) update over one 128-bit block.
// Bytes are consumed lowest-offset first ([127:120] first), 16 unrolled steps.
//   crc_in   in   32   running CRC register (not inverted)
//   data     in   128  block to fold in
//   crc_out  out  32   updated CRC register (not inverted)
// -----------------------------------------------------------------------------
module crc32_d128
   import serpent_xts_pkg::*;
(
   input  logic [31:0]  crc_in,
   input  logic [127:0] data,
   output logic [31:0]  crc_out
);

   always_comb begin
      crc_out = crc_in;
      for (int i = 0; i < 16; i++) begin
         crc_out = crc_out ^ {24'd0, blk_byte(data, i)};
         for (int k = 0; k < 8; k++) begin
            crc_out = crc_out[0] ? ((crc_out >> 1) ^ CRC32_POLY) : (crc_out >> 1);
         end
      end
   end

endmodule

// File: rtl/serpent_xts_hdr_check.sv
// -----------------------------------------------------------------------------
// serpent_xts_hdr_check
// Judges one candidate key from the 28 decrypted header blocks (offsets
// 64..511): "VERA" magic in block 0 and the CRC-32 of bytes 256..511 against
// the value stored at offset 72. One verdict per candidate; every beat is
// always consumed so the decryptor never stalls.
//   i_clk   in  1   clock
//   i_rst   in  1   synchronous reset, active-high
//   bus     slave modport of serpent_xts_hdr_check_if (start/data in,
//           busy/done/match/magic_ok/blk_cnt out)
// -----------------------------------------------------------------------------
module serpent_xts_hdr_check
   import serpent_xts_pkg::*;
#(
   parameter int          NUM_BLOCKS    = HDR_NUM_BLOCKS,
   parameter logic [31:0] MAGIC         = HDR_MAGIC,
   parameter int          CRC_FIRST_BLK = serpent_xts_pkg::CRC_FIRST_BLK,
   parameter int          CRC_LAST_BLK  = serpent_xts_pkg::CRC_LAST_BLK
)(
   input  logic                    i_clk,
   input  logic                    i_rst,
   serpent_xts_hdr_check_if.slave  bus
);

   localparam logic [1:0] IDLE = ST_IDLE;
   localparam logic [1:0] RUN  = ST_RUN;
   localparam logic [1:0] DONE = ST_DONE;

   logic [1:0]  state, state_nxt;
   logic [4:0]  blk_cnt, blk_idx, cnt_nxt;
   logic [31:0] crc, crc_base, crc_upd, crc_nxt;
   logic [31:0] stored_crc, stored_nxt;
   logic        magic_ok, magic_nxt;
   logic        match;
   logic        accept, in_crc_range, last_blk;

   crc32_d128 u_crc (
      .crc_in  (crc_base),
      .data    (bus.i_data),
      .crc_out (crc_upd)
   );

   // A start pulse rebases everything to block 0 in the same cycle, so a
   // beat arriving together with i_start is folded in as block 0.
   always_comb begin
      accept       = bus.i_data_valid & (bus.i_start | (state == RUN));
      blk_idx      = bus.i_start ? 5'd0 : blk_cnt;
      crc_base     = bus.i_start ? CRC32_INIT : crc;
      in_crc_range = (blk_idx >= 5'(CRC_FIRST_BLK)) && (blk_idx <= 5'(CRC_LAST_BLK));
      crc_nxt      = (accept && in_crc_range) ? crc_upd : crc_base;
      magic_nxt    = bus.i_start ? 1'b0  : magic_ok;
      stored_nxt   = bus.i_start ? 32'd0 : stored_crc;
      if (accept && (blk_idx == 5'd0)) begin
         magic_nxt  = (be_word(bus.i_data, 0) == MAGIC);
         stored_nxt = be_word(bus.i_data, 2);     // offset 72..75
      end
      last_blk = accept && (blk_idx == 5'(NUM_BLOCKS - 1));
      cnt_nxt  = blk_idx + 5'(accept);

      // DONE always lasts one cycle (o_done pulses for the old candidate
      // even if a new start lands on it); start overrides, last block wins.
      state_nxt = state;
      case (state)
         RUN:     state_nxt = RUN;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (bus.i_start) state_nxt = RUN;
      if (last_blk)    state_nxt = DONE;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state      <= IDLE;
         blk_cnt    <= 5'd0;
         crc        <= CRC32_INIT;
         stored_crc <= 32'd0;
         magic_ok   <= 1'b0;
         match      <= 1'b0;
      end else begin
         state      <= state_nxt;
         blk_cnt    <= cnt_nxt;
         crc        <= crc_nxt;
         stored_crc <= stored_nxt;
         magic_ok   <= magic_nxt;
         if (last_blk) begin
            match <= magic_nxt & ((~crc_nxt) == stored_nxt);
         end
      end
   end

   assign bus.o_busy     = (state == RUN);
   assign bus.o_done     = (state == DONE);
   assign bus.o_match    = match & (state == DONE);
   assign bus.o_magic_ok = magic_ok;
   assign bus.o_blk_cnt  = blk_cnt;

endmodule

// File: tb/tb_serpent_xts_hdr_check.sv
// -----------------------------------------------------------------------------
// tb_serpent_xts_hdr_check
// Self-checking bench for serpent_xts_hdr_check: directed header cases plus
// random candidates judged by a byte-offset model of the header.
// -----------------------------------------------------------------------------
module tb_serpent_xts_hdr_check;

   typedef logic [127:0] cand_t [28];

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   serpent_xts_hdr_check_if bus();

   serpent_xts_hdr_check dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;
   cand_t case1;

   // ---------------- reference model (header byte offsets) ----------------
   function automatic logic [31:0] model_crc(input cand_t blk);
      logic [7:0]  hdr [512];
      logic [31:0] c;
      for (int b = 0; b < 28; b++)
         for (int k = 0; k < 16; k++)
            hdr[64 + 16*b + k] = blk[b][127-8*k -: 8];
      c = 32'hFFFFFFFF;
      for (int off = 256; off < 512; off++) begin
         c = c ^ {24'h0, hdr[off]};
         for (int j = 0; j < 8; j++)
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
      return ~c;
   endfunction

   function automatic logic model_match(input cand_t blk, output logic magic);
      logic [31:0] stored;
      magic  = (blk[0][127:96] == 32'h56455241);   // bytes 64..67
      stored = blk[0][63:32];                      // bytes 72..75
      return magic && (model_crc(blk) == stored);
   endfunction

   // ---------------- stimulus driver (no comparisons) ----------------------
   task automatic send_cand(input cand_t blk, input int n_send, input int gap_pct,
                            input bit b0_with_start, input bit no_wait,
                            output int ndone, output logic ontime,
                            output logic vmatch, output logic vmagic0,
                            output logic vmagic_end, output logic [4:0] vcnt);
      int  i;
      bit  prev_b0;
      bit  fin;
      ndone = 0; ontime = 0; vmatch = 0; vmagic0 = 0; vmagic_end = 0; vcnt = 0;
      if (!no_wait) @(negedge clk);
      bus.i_start = 1'b1;
      i = 0;
      if (b0_with_start) begin
         bus.i_data_valid = 1'b1;
         bus.i_data       = blk[0];
         i = 1;
      end else begin
         bus.i_data_valid = 1'b0;
         bus.i_data       = {$urandom, $urandom, $urandom, $urandom};
      end
      prev_b0 = b0_with_start;
      fin = 0;
      while (!fin) begin
         @(negedge clk);
         bus.i_start = 1'b0;
         if (bus.o_done) ndone++;
         if (prev_b0) vmagic0 = bus.o_magic_ok;
         prev_b0 = 0;
         if (i == n_send) begin
            ontime     = bus.o_done;
            vmatch     = bus.o_match;
            vmagic_end = bus.o_magic_ok;
            vcnt       = bus.o_blk_cnt;
            bus.i_data_valid = 1'b0;
            fin = 1;
         end else if ($urandom_range(99) < gap_pct) begin
            bus.i_data_valid = 1'b0;
            bus.i_data       = {$urandom, $urandom, $urandom, $urandom};
         end else begin
            bus.i_data_valid = 1'b1;
            bus.i_data       = blk[i];
            if (i == 0) prev_b0 = 1;
            i++;
         end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      bus.i_start = 1'b1;
      bus.i_data_valid = 1'b1;
      bus.i_data = case1[0];
      repeat (3) @(negedge clk);
      n_checks++; if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.o_busy); end
      n_checks++; if (bus.o_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.o_done); end
      n_checks++; if (bus.o_match !== 1'b0) begin n_fail++; $display("FAIL reset_match: got %b want 0", bus.o_match); end
      n_checks++; if (bus.o_magic_ok !== 1'b0) begin n_fail++; $display("FAIL reset_magic: got %b want 0", bus.o_magic_ok); end
      n_checks++; if (bus.o_blk_cnt !== 5'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", bus.o_blk_cnt); end
      rst = 1'b0;
      bus.i_start = 1'b0;
      bus.i_data_valid = 1'b0;
      @(negedge clk);
      n_checks++; if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_busy: got %b want 0", bus.o_busy); end
   endtask

   task automatic test_valid();
      int nd; logic ot, m, mg0, mge; logic [4:0] c;
      send_cand(case1, 28, 0, 1'b1, 1'b0, nd, ot, m, mg0, mge, c);
      n_checks++; if (ot !== 1'b1) begin n_fail++; $display("FAIL valid_done_latency: got %b want 1", ot); end
      n_checks++; if (m !== 1'b1) begin n_fail++; $display("FAIL valid_match: got %b want 1", m); end
      n_checks++; if (mg0 !== 1'b1) begin n_fail++; $display("FAIL valid_magic_b0: got %b want 1", mg0); end
      n_checks++; if (c !== 5'd28) begin n_fail++; $display("FAIL valid_blk_cnt: got %0d want 28", c); end
      @(negedge clk);
      n_checks++; if (bus.o_done !== 1'b0) begin n_fail++; $display("FAIL valid_done_width: got %b want 0", bus.o_done); end
   endtask

   task automatic test_bad_magic();
      cand_t b; int nd; logic ot, m, mg0, mge; logic [4:0] c;
      b = case1;
      b[0][127:96] = 32'h56455242;
      send_cand(b, 28, 0, 1'b0, 1'b0, nd, ot, m, mg0, mge, c);
      n_checks++; if (mg0 !== 1'b0) begin n_fail++; $display("FAIL badmagic_magic_b0: got %b want 0", mg0); end
      n_checks++; if (ot !== 1'b1) begin n_fail++; $display("FAIL badmagic_done: got %b want 1", ot); end
      n_checks++; if (m !== 1'b0) begin n_fail++; $display("FAIL badmagic_match: got %b want 0", m); end
   endtask

   task automatic test_bad_crc();
      cand_t b; int nd; logic ot, m, mg0, mge; logic [4:0] c;
      b = case1;
      b[20] = 128'h1;
      send_cand(b, 28, 0, 1'b0, 1'b0, nd, ot, m, mg0, mge, c);
      n_checks++; if (ot !== 1'b1) begin n_fail++; $display("FAIL badcrc_done: got %b want 1", ot); end
      n_checks++; if (m !== 1'b0) begin n_fail++; $display("FAIL badcrc_match: got %b want 0", m); end
      n_checks++; if (mge !== 1'b1) begin n_fail++; $display("FAIL badcrc_magic: got %b want 1", mge); end
   endtask

   task automatic test_restart();
      int nd1, nd2, nq; logic ot, m, mg0, mge; logic [4:0] c;
      send_cand(case1, 11, 0, 1'b0, 1'b0, nd1, ot, m, mg0, mge, c);
      send_cand(case1, 28, 0, 1'b0, 1'b1, nd2, ot, m, mg0, mge, c);
      nq = 0;
      repeat (3) begin @(negedge clk); if (bus.o_done) nq++; end
      n_checks++; if (nd1 + nd2 + nq != 1) begin n_fail++; $display("FAIL restart_done_count: got %0d want 1", nd1 + nd2 + nq); end
      n_checks++; if (ot !== 1'b1) begin n_fail++; $display("FAIL restart_done_latency: got %b want 1", ot); end
      n_checks++; if (m !== 1'b1) begin n_fail++; $display("FAIL restart_match: got %b want 1", m); end
   endtask

   task automatic test_gaps();
      int nd; logic ot, m, mg0, mge; logic [4:0] c, cnt0;
      logic bad;
      cnt0 = bus.o_blk_cnt;
      bad = 0;
      for (int k = 0; k < 6; k++) begin
         bus.i_data_valid = 1'b1;
         bus.i_data = (k == 0) ? case1[0] : {$urandom, $urandom, $urandom, $urandom};
         @(negedge clk);
         if (bus.o_busy !== 1'b0 || bus.o_done !== 1'b0 || bus.o_blk_cnt !== cnt0) bad = 1;
      end
      bus.i_data_valid = 1'b0;
      n_checks++; if (bad !== 1'b0) begin n_fail++; $display("FAIL idle_beats_ignored: cnt %0d want %0d busy %b", bus.o_blk_cnt, cnt0, bus.o_busy); end
      send_cand(case1, 28, 30, 1'b0, 1'b1, nd, ot, m, mg0, mge, c);
      n_checks++; if (ot !== 1'b1) begin n_fail++; $display("FAIL gaps_done: got %b want 1", ot); end
      n_checks++; if (m !== 1'b1) begin n_fail++; $display("FAIL gaps_match: got %b want 1", m); end
      n_checks++; if (nd != 1) begin n_fail++; $display("FAIL gaps_done_count: got %0d want 1", nd); end
   endtask

   task automatic test_mid_reset();
      int nd, nq; logic ot, m, mg0, mge; logic [4:0] c;
      send_cand(case1, 15, 0, 1'b0, 1'b0, nd, ot, m, mg0, mge, c);
      rst = 1'b1;
      bus.i_data_valid = 1'b1;
      bus.i_data = case1[15];
      @(negedge clk);
      rst = 1'b0;
      bus.i_data_valid = 1'b0;
      n_checks++; if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b want 0", bus.o_busy); end
      n_checks++; if (bus.o_blk_cnt !== 5'd0) begin n_fail++; $display("FAIL midreset_cnt: got %0d want 0", bus.o_blk_cnt); end
      nq = nd;
      for (int k = 0; k < 16; k++) begin
         bus.i_data_valid = 1'b1;
         bus.i_data = case1[k];
         @(negedge clk);
         if (bus.o_done) nq++;
      end
      bus.i_data_valid = 1'b0;
      n_checks++; if (nq != 0) begin n_fail++; $display("FAIL midreset_no_done: got %0d want 0", nq); end
      send_cand(case1, 28, 10, 1'b1, 1'b0, nd, ot, m, mg0, mge, c);
      n_checks++; if (ot !== 1'b1 || m !== 1'b1) begin n_fail++; $display("FAIL midreset_recover: done %b match %b want 1 1", ot, m); end
   endtask

   task automatic make_rand(output cand_t b, input bit good);
      for (int k = 0; k < 28; k++) b[k] = {$urandom, $urandom, $urandom, $urandom};
      if (good) begin
         b[0][127:96] = 32'h56455241;
         b[0][63:32]  = model_crc(b);
      end else if ($urandom_range(1) == 1) begin
         b[0][127:96] = 32'h56455241;
      end
   endtask

   task automatic test_random();
      cand_t b; int nd; logic ot, m, mg0, mge, em, emg; logic [4:0] c;
      for (int t = 0; t < 6; t++) begin
         make_rand(b, (t % 2) == 0);
         em = model_match(b, emg);
         send_cand(b, 28, 20, 1'($urandom_range(1)), 1'b0, nd, ot, m, mg0, mge, c);
         n_checks++; if (ot !== 1'b1 || m !== em) begin n_fail++; $display("FAIL random_%0d_verdict: done %b match %b want 1 %b", t, ot, m, em); end
         n_checks++; if (mge !== emg) begin n_fail++; $display("FAIL random_%0d_magic: got %b want %b", t, mge, emg); end
      end
   endtask

   task automatic test_back_to_back();
      cand_t a, b; int nda, ndb, nq; logic ota, ma, otb, mb, mg0, mge, ea, eb, dmy; logic [4:0] c;
      make_rand(a, 1'b1);
      make_rand(b, 1'b0);
      b[0][127:96] = 32'h56455241;
      ea = model_match(a, dmy);
      eb = model_match(b, dmy);
      send_cand(a, 28, 0, 1'b1, 1'b0, nda, ota, ma, mg0, mge, c);
      send_cand(b, 28, 0, 1'b1, 1'b1, ndb, otb, mb, mg0, mge, c);
      nq = 0;
      repeat (3) begin @(negedge clk); if (bus.o_done) nq++; end
      n_checks++; if (ota !== 1'b1 || ma !== ea) begin n_fail++; $display("FAIL b2b_first: done %b match %b want 1 %b", ota, ma, ea); end
      n_checks++; if (otb !== 1'b1 || mb !== eb) begin n_fail++; $display("FAIL b2b_second: done %b match %b want 1 %b", otb, mb, eb); end
      n_checks++; if (nda + ndb + nq != 2) begin n_fail++; $display("FAIL b2b_done_count: got %0d want 2", nda + ndb + nq); end
      n_checks++; if (mg0 !== 1'b1) begin n_fail++; $display("FAIL b2b_magic_b0: got %b want 1", mg0); end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int k = 0; k < 28; k++) case1[k] = 128'h0;
      case1[0] = 128'h56455241_0005_010B_0D968558_00000000;
      bus.i_start = 1'b0;
      bus.i_data_valid = 1'b0;
      bus.i_data = 128'h0;
      test_reset();
      test_valid();
      test_bad_magic();
      test_bad_crc();
      test_restart();
      test_gaps();
      test_mid_reset();
      test_random();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
